op_decoder: RTL and testbench

Parametrised successor to the single-operator comparator: decodes a stream of ASCII operator characters into numeric operation codes for the co-processor's ALU dispatch. Handles eleven single-character operators and four two-character operators ("<<", ">>", "**", "=="), using a lookahead state machine, an idle flush timeout and a one-cycle busy handshake. It sits between the host character receiver and the ALU op register.

---
 rtl/op_decoder.sv | 172 +++++++++++++++++
 tb/tb_op_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/op_decoder.sv
// ============================================================================
// Module      : op_decoder
// Description : Decodes a stream of ASCII operator characters into ALU
//               operation codes. A lookahead FSM pairs "<<", ">>", "**" and
//               "==", flushes a lone pair-start character after an idle
//               timeout, and holds a following single operator for one
//               busy cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_decoder #(
    parameter int OP_W    = 8,
    parameter int TIMEOUT = 16,
    parameter int PAIR_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      op,
    input  logic            i_ready,
    output logic [OP_W-1:0] op_code,
    output logic            o_ready,
    output logic            o_err,
    output logic            o_busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        pend_q, pend_d;
    logic [3:0]        hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   code_q, code_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    // Code for a character decoded on its own; 0 means "not an operator".
    function automatic logic [3:0] single_code(input logic [7:0] c);
        case (c)
            8'h2B:   single_code = 4'd1;   // +
            8'h2D:   single_code = 4'd2;   // -
            8'h2A:   single_code = 4'd3;   // *
            8'h2F:   single_code = 4'd4;   // /
            8'h26:   single_code = 4'd5;   // &
            8'h7C:   single_code = 4'd6;   // |
            8'h5E:   single_code = 4'd7;   // ^
            8'h7E:   single_code = 4'd8;   // ~
            8'h3C:   single_code = 4'd9;   // <
            8'h3E:   single_code = 4'd10;  // >
            8'h3D:   single_code = 4'd15;  // =
            default: single_code = 4'd0;
        endcase
    endfunction

    // Code for a doubled pair-start character.
    function automatic logic [3:0] pair_code(input logic [7:0] c);
        case (c)
            8'h3C:   pair_code = 4'd11;    // <<
            8'h3E:   pair_code = 4'd12;    // >>
            8'h2A:   pair_code = 4'd13;    // **
            default: pair_code = 4'd14;    // ==
        endcase
    endfunction

    function automatic logic is_pair_start(input logic [7:0] c);
        is_pair_start = (c == 8'h3C) || (c == 8'h3E) || (c == 8'h2A) || (c == 8'h3D);
    endfunction

    // Next-state, pending/held storage, timeout count and emitted outputs.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_ready) begin
                    if (op == SPACE) begin
                        state_d = S_IDLE;
                    end else if ((PAIR_EN != 0) && is_pair_start(op)) begin
                        state_d = S_PEND;
                        pend_d  = op;
                        cnt_d   = '0;
                    end else if (single_code(op) != 4'd0) begin
                        code_d  = OP_W'(single_code(op));
                        ready_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PEND: begin
                if (i_ready) begin
                    // Any follower flushes the pending character unless it completes the pair.
                    ready_d = 1'b1;
                    code_d  = OP_W'(single_code(pend_q));
                    state_d = S_IDLE;
                    if (op == pend_q) begin
                        code_d = OP_W'(pair_code(pend_q));
                    end else if (op == SPACE) begin
                        state_d = S_IDLE;
                    end else if (is_pair_start(op)) begin
                        state_d = S_PEND;
                        pend_d  = op;
                        cnt_d   = '0;
                    end else if (single_code(op) != 4'd0) begin
                        state_d = S_HOLD;
                        hold_d  = single_code(op);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
                    ready_d = 1'b1;
                    code_d  = OP_W'(single_code(pend_q));
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // The held operator always emits; a character offered now is dropped.
                ready_d = 1'b1;
                code_d  = OP_W'(hold_q);
                state_d = S_IDLE;
                err_d   = i_ready;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign op_code = code_q;
    assign o_ready = ready_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q == S_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_op_decoder.sv
// ============================================================================
// Module      : tb_op_decoder
// Description : Directed testbench for op_decoder. Drives a default-parameter
//               instance and a PAIR_EN=0 / OP_W=4 instance from the same
//               character stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_op_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] op;
    logic       i_ready;

    logic [7:0] op_code;
    logic       o_ready, o_err, o_busy;
    logic [3:0] op_code1;
    logic       o_ready1, o_err1, o_busy1;

    int checks;
    int failures;

    op_decoder #(.OP_W(8), .TIMEOUT(16), .PAIR_EN(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .i_ready (i_ready),
        .op_code (op_code),
        .o_ready (o_ready),
        .o_err   (o_err),
        .o_busy  (o_busy)
    );

    op_decoder #(.OP_W(4), .TIMEOUT(16), .PAIR_EN(0)) dut_np (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .i_ready (i_ready),
        .op_code (op_code1),
        .o_ready (o_ready1),
        .o_err   (o_err1),
        .o_busy  (o_busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one character for one edge; returns 1 time unit after the edge.
    task automatic send(input logic [7:0] c);
        op      = c;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        op      = 8'h00;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Default instance: ready/err/busy/code after the latest edge.
    task automatic expect_out(input string name, input logic rdy, input logic err,
                              input logic busy, input logic [7:0] code);
        checks++;
        if (o_ready !== rdy || o_err !== err || o_busy !== busy || op_code !== code) begin
            failures++;
            $display("FAIL %s: got rdy=%b err=%b busy=%b code=%h, want rdy=%b err=%b busy=%b code=%h",
                     name, o_ready, o_err, o_busy, op_code, rdy, err, busy, code);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        op      = 8'h00;
        i_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        expect_out("reset_dut", 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (o_ready1 !== 1'b0 || o_err1 !== 1'b0 || o_busy1 !== 1'b0 || op_code1 !== 4'h0) begin
            failures++;
            $display("FAIL reset_np: got rdy=%b err=%b busy=%b code=%h, want all 0",
                     o_ready1, o_err1, o_busy1, op_code1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_single();
        send("+");
        expect_out("single_plus", 1'b1, 1'b0, 1'b0, 8'h01);
        send("/");
        expect_out("single_div", 1'b1, 1'b0, 1'b0, 8'h04);
        idle();
        expect_out("single_hold_value", 1'b0, 1'b0, 1'b0, 8'h04);
    endtask

    task automatic test_pairs();
        send("<");
        expect_out("pair_lt_first", 1'b0, 1'b0, 1'b0, 8'h04);
        send("<");
        expect_out("pair_shl", 1'b1, 1'b0, 1'b0, 8'h0B);
        send("*");
        send("*");
        expect_out("pair_pow", 1'b1, 1'b0, 1'b0, 8'h0D);
        send("=");
        send("=");
        expect_out("pair_eq", 1'b1, 1'b0, 1'b0, 8'h0E);
        // Different pair-start flushes the first and becomes pending itself.
        send("<");
        send(">");
        expect_out("pair_switch_flush", 1'b1, 1'b0, 1'b0, 8'h09);
        send(">");
        expect_out("pair_shr", 1'b1, 1'b0, 1'b0, 8'h0C);
        // Space flushes the pending character.
        send("*");
        send(" ");
        expect_out("pend_space", 1'b1, 1'b0, 1'b0, 8'h03);
    endtask

    task automatic test_follower();
        send("<");
        send("-");
        expect_out("follow_pending", 1'b1, 1'b0, 1'b1, 8'h09);
        send("+");
        expect_out("follow_held_drop", 1'b1, 1'b1, 1'b0, 8'h02);
        idle();
        expect_out("follow_after", 1'b0, 1'b0, 1'b0, 8'h02);
    endtask

    task automatic test_timeout();
        int early;
        send(">");
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            idle();
            if (o_ready !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL timeout_early: got %0d early emissions, want 0", early);
        end
        idle();
        expect_out("timeout_expire", 1'b1, 1'b0, 1'b0, 8'h0A);
        // Character on the expiry cycle wins over the flush.
        send(">");
        for (int k = 1; k <= 15; k++) idle();
        send(">");
        expect_out("timeout_char_wins", 1'b1, 1'b0, 1'b0, 8'h0C);
        idle();
        expect_out("timeout_no_extra", 1'b0, 1'b0, 1'b0, 8'h0C);
    endtask

    task automatic test_unknown();
        send("+");
        send("A");
        expect_out("unknown_idle", 1'b0, 1'b1, 1'b0, 8'h01);
        send("*");
        send("A");
        expect_out("unknown_pend", 1'b1, 1'b1, 1'b0, 8'h03);
        idle();
        expect_out("unknown_after", 1'b0, 1'b0, 1'b0, 8'h03);
    endtask

    task automatic test_reset_pend();
        int spurious;
        send("<");
        #2;
        reset = 1'b0;
        #1;
        expect_out("reset_pend_now", 1'b0, 1'b0, 1'b0, 8'h00);
        idle();
        reset = 1'b1;
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            if (o_ready !== 1'b0 || op_code !== 8'h00) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reset_pend_discard: got %0d cycles with output, want 0", spurious);
        end
    endtask

    task automatic test_nopair();
        logic [7:0] chars [5];
        logic [3:0] codes [5];
        logic       rdys  [5];
        logic       errs  [5];
        chars = '{8'h3C, 8'h2A, 8'h3D, 8'h20, 8'h41};
        codes = '{4'h9, 4'h3, 4'hF, 4'hF, 4'hF};
        rdys  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        errs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send(chars[i]);
            checks++;
            if (o_ready1 !== rdys[i] || o_err1 !== errs[i] || o_busy1 !== 1'b0 || op_code1 !== codes[i]) begin
                failures++;
                $display("FAIL nopair_%0d: got rdy=%b err=%b busy=%b code=%h, want rdy=%b err=%b busy=0 code=%h",
                         i, o_ready1, o_err1, o_busy1, op_code1, rdys[i], errs[i], codes[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_pairs();
        test_follower();
        test_timeout();
        test_unknown();
        test_reset_pend();
        test_nopair();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
